mem_request_unit: RTL and testbench
===================================

# mem_request_unit

Memory request unit between the single-cycle core and a single-port, variable-latency instruction/data RAM. It arbitrates instruction fetches (from the PC) and data loads/stores (from the control/ALU path) onto one RAM port. It holds each request until the RAM acknowledges, then returns the fetched word or load data with a one-cycle `i_ready`/`d_ready` pulse. It also flags misaligned addresses and RAM timeouts.

## Interface
- `TIMEOUT`, default 64: max cycles a RAM access may wait for `ram_ack` before abort; must be ≥ 1.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `i_req`  in  1  instruction fetch request, level.
- `imemaddr`  in  32  fetch address (PC).
- `d_ren`  in  1  data load request, level.
- `d_wen`  in  1  data store request, level.
- `dmemaddr`  in  32  data address (ALU result).
- `dmemstore`  in  32  store data.
- `imemload`  out  32  fetched instruction, registered.
- `i_ready`  out  1  one-cycle pulse: fetch complete, `imemload` valid.
- `dmemload`  out  32  load data, registered.
- `d_ready`  out  1  one-cycle pulse: data access complete.
- `err`  out  1  one-cycle pulse, coincident with the ready pulse, for a misaligned or timed-out access.
- `ramaddr`  out  32  RAM word address (byte address, bits [1:0] = 0).
- `ramstore`  out  32  RAM write data.
- `ram_ren`  out  1  RAM read strobe, held until ack.
- `ram_wen`  out  1  RAM write strobe, held until ack.
- `ramload`  in  32  RAM read data, valid with `ram_ack`.
- `ram_ack`  in  1  RAM completion, one-cycle pulse.

## Operation
- FSM states:
  - IDLE: no access in flight; samples requests.
  - IREQ: fetch in flight.
  - DREQ: load or store in flight.
  - DONE: completion cycle; drives the ready pulse.
- IDLE arbitration, first match wins:
  - If `d_wen` or `d_ren` is high, take DREQ. Data has priority because it belongs to the current instruction.
  - If `d_wen` and `d_ren` are both high, the access is a store.
  - Else if `i_req` is high, take IREQ.
  - Else stay in IDLE.
- On acceptance, latch the address, the store data and the access type. RAM outputs come only from latched values, so core inputs may change freely mid-access.
- If the accepted address has bits [1:0] ≠ 0, issue no RAM strobe. Go directly to DONE with `err` = 1. Outputs `imemload`/`dmemload` are unchanged.
- IREQ/DREQ:
  - Hold `ram_ren` (or `ram_wen`) with `ramaddr`/`ramstore` stable until `ram_ack`.
  - On `ram_ack`, capture `ramload` into `imemload` (fetch) or `dmemload` (load); stores leave `dmemload` unchanged. Then go to DONE.
- Timeout counter:
  - Cleared on acceptance; increments each cycle in IREQ/DREQ without `ram_ack`.
  - When it reaches `TIMEOUT`, drop the strobe and go to DONE with `err` = 1. The captured data register is written to 0.
  - `ram_ack` arriving in the same cycle as the timeout wins: normal completion, no `err`.
- DONE:
  - Assert `i_ready` (fetch) or `d_ready` (data) for exactly one cycle, with `err` as determined.
  - No request is sampled. Next state is IDLE, so a still-high request with a stale address is not re-issued in the same cycle.
- `ram_ack` in IDLE or DONE is ignored.
- At most one of `ram_ren`/`ram_wen` is high at any time. Both are low outside IREQ/DREQ.

## Timing
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - `ram_ren`, `ram_wen`, `i_ready`, `d_ready`, `err` go to 0.
  - `ramaddr`, `ramstore`, `imemload`, `dmemload` go to 0; the counter goes to 0.
  - Reset mid-access abandons the access with no ready pulse; the RAM sees its strobe drop asynchronously.
- Strobes and ready/err are registered state-decoded outputs with no combinational path from core inputs.
- Cycle numbering, request seen in IDLE at edge 0:
  - Cycles 1..k: strobe high.
  - `ram_ack` is seen at edge k.
  - Cycle k+1: DONE, ready pulse and data valid.
  - Cycle k+2: IDLE.
- Minimum latency (ack in the first strobe cycle) is request → ready = 2 cycles; back-to-back accesses start every 3 cycles at best.
- Misaligned access: request edge 0 → DONE at cycle 1 with the ready and `err` pulse.
- Timeout: strobe is high for exactly `TIMEOUT` cycles; the ready and `err` pulse follows in the next cycle.

## Test plan
- Fetch, ack after 3 cycles: `i_req`=1, `imemaddr`=0x0000_0010, `ramload`=0x0020_8093 with ack on the 3rd strobe cycle → `ram_ren` high exactly 3 cycles at `ramaddr`=0x10, then `i_ready`=1 for one cycle with `imemload`=0x0020_8093, `err`=0.
- Simultaneous requests: `i_req`=1 and `d_wen`=1 at `dmemaddr`=0x100, `dmemstore`=0xCAFE_F00D, immediate acks → store performed first (`ram_wen`, `ramaddr`=0x100, `ramstore`=0xCAFEF00D), then `d_ready`, one DONE cycle, then the fetch is issued.
- Load with zero-latency ack → `d_ready` 2 cycles after the request, `dmemload`=`ramload`. Also drive `d_ren`=`d_wen`=1 → store issued, not load.
- Misaligned: `d_ren`=1, `dmemaddr`=0x102 → no strobe ever; `d_ready`=`err`=1 at cycle 1; `dmemload` unchanged.
- Timeout with `TIMEOUT`=4 and no ack → `ram_ren` high 4 cycles, then `i_ready`=`err`=1 and `imemload`=0. Repeat with ack on the 4th cycle → normal completion, `err`=0.
- Reset asserted in cycle 2 of a pending store → `ram_wen` low immediately, no `d_ready`; after release a new fetch completes normally.

Source files
------------

// File: rtl/mem_request_unit.sv
// Single-port RAM request unit: arbitrates core fetches and data accesses onto one
// variable-latency RAM port, with misalignment and timeout reporting.
module mem_request_unit #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] imemaddr,
  input  logic        d_ren,
  input  logic        d_wen,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic [31:0] imemload,
  output logic        i_ready,
  output logic [31:0] dmemload,
  output logic        d_ready,
  output logic        err,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  output logic        ram_ren,
  output logic        ram_wen,
  input  logic [31:0] ramload,
  input  logic        ram_ack
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, IREQ, DREQ, DONE} state_t;
  typedef struct packed {
    logic data;
    logic store;
  } acc_t;

  state_t        state, state_n;
  acc_t          acc, acc_n, tacc;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0]   addr_n, wdata_n, iload_n, dload_n, taddr;
  logic          ren_n, wen_n, irdy_n, drdy_n, err_n, take;

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    addr_n  = ramaddr;
    wdata_n = ramstore;
    iload_n = imemload;
    dload_n = dmemload;
    ren_n   = ram_ren;
    wen_n   = ram_wen;
    irdy_n  = 1'b0;
    drdy_n  = 1'b0;
    err_n   = 1'b0;
    // data beats fetch: it belongs to the instruction already executing
    take       = 1'b0;
    taddr      = imemaddr;
    tacc.data  = 1'b0;
    tacc.store = 1'b0;
    if (d_wen || d_ren) begin
      take       = 1'b1;
      taddr      = dmemaddr;
      tacc.data  = 1'b1;
      tacc.store = d_wen;
    end else if (i_req) begin
      take = 1'b1;
    end

    case (state)
      IDLE: if (take) begin
        acc_n   = tacc;
        addr_n  = {taddr[31:2], 2'b00};
        wdata_n = dmemstore;
        cnt_n   = '0;
        if (taddr[1:0] != 2'b00) begin
          state_n = DONE;
          err_n   = 1'b1;
          irdy_n  = !tacc.data;
          drdy_n  = tacc.data;
        end else begin
          state_n = tacc.data ? DREQ : IREQ;
          ren_n   = !tacc.store;
          wen_n   = tacc.store;
        end
      end
      IREQ, DREQ: begin
        // an ack landing on the timeout cycle still counts as a clean completion
        if (ram_ack || cnt == CW'(TIMEOUT - 1)) begin
          state_n = DONE;
          ren_n   = 1'b0;
          wen_n   = 1'b0;
          err_n   = !ram_ack;
          irdy_n  = !acc.data;
          drdy_n  = acc.data;
          if (!acc.store) begin
            if (acc.data) dload_n = ram_ack ? ramload : '0;
            else          iload_n = ram_ack ? ramload : '0;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      ramaddr  <= '0;
      ramstore <= '0;
      imemload <= '0;
      dmemload <= '0;
      ram_ren  <= 1'b0;
      ram_wen  <= 1'b0;
      i_ready  <= 1'b0;
      d_ready  <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      acc      <= acc_n;
      cnt      <= cnt_n;
      ramaddr  <= addr_n;
      ramstore <= wdata_n;
      imemload <= iload_n;
      dmemload <= dload_n;
      ram_ren  <= ren_n;
      ram_wen  <= wen_n;
      i_ready  <= irdy_n;
      d_ready  <= drdy_n;
      err      <= err_n;
    end
  end
endmodule

// File: tb/tb_mem_request_unit.sv
// Bench for mem_request_unit (TIMEOUT=4): directed scenarios plus randomized
// accesses checked against a per-transaction latency/data model.
module tb_mem_request_unit;
  localparam int T = 4;

  logic        clk = 1'b0, rst = 1'b1;
  logic        i_req = 0, d_ren = 0, d_wen = 0, ram_ack = 0;
  logic [31:0] imemaddr = 0, dmemaddr = 0, dmemstore = 0, ramload = 0;
  logic [31:0] imemload, dmemload, ramaddr, ramstore;
  logic        i_ready, d_ready, err, ram_ren, ram_wen;

  int checks = 0, errors = 0;

  mem_request_unit #(.TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .imemaddr(imemaddr),
    .d_ren(d_ren), .d_wen(d_wen), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .imemload(imemload), .i_ready(i_ready), .dmemload(dmemload), .d_ready(d_ready),
    .err(err), .ramaddr(ramaddr), .ramstore(ramstore), .ram_ren(ram_ren),
    .ram_wen(ram_wen), .ramload(ramload), .ram_ack(ram_ack)
  );

  always #5 clk = ~clk;

  // observations of one access
  int          o_strb, o_lat, o_width;
  logic        o_ren, o_wen, o_both, o_stable, o_ir, o_dr, o_err;
  logic [31:0] o_addr, o_store, o_iload, o_dload;
  // model state and expectations
  logic [31:0] m_imem = 0, m_dmem = 0;
  int          e_strb, e_lat;
  logic        e_ren, e_wen, e_ir, e_dr, e_err;
  logic [31:0] e_addr;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Drives one request from IDLE, plays RAM with an ack on strobe cycle ack_at
  // (0 = never), and records what the DUT did. Returns in the cycle after the pulse.
  task automatic do_access(input logic ir, dr, dw, input logic [31:0] ia, da, ds, rl,
                           input int ack_at);
    o_strb = 0; o_lat = -1; o_width = 0; o_ren = 0; o_wen = 0; o_both = 0;
    o_stable = 1; o_ir = 0; o_dr = 0; o_err = 0; o_addr = 0; o_store = 0;
    o_iload = 0; o_dload = 0;
    i_req = ir; d_ren = dr; d_wen = dw; imemaddr = ia; dmemaddr = da; dmemstore = ds;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 1) begin
        i_req = 0; d_ren = 0; d_wen = 0;
        imemaddr = $urandom; dmemaddr = $urandom; dmemstore = $urandom;
      end
      if (ram_ren || ram_wen) begin
        if (o_strb == 0) begin o_addr = ramaddr; o_store = ramstore; end
        else if (ramaddr !== o_addr || ramstore !== o_store) o_stable = 0;
        o_strb++;
        if (ram_ren) o_ren = 1;
        if (ram_wen) o_wen = 1;
        if (ram_ren && ram_wen) o_both = 1;
      end
      ram_ack = (c == ack_at);
      ramload = (c == ack_at) ? rl : $urandom;
      if (i_ready || d_ready) begin
        if (o_lat < 0) begin
          o_lat = c; o_ir = i_ready; o_dr = d_ready; o_err = err;
          o_iload = imemload; o_dload = dmemload;
        end
        o_width++;
      end else if (o_lat >= 0) begin
        break;
      end
    end
    ram_ack = 0;
  endtask

  // Expected behaviour of one access, from the block's rules.
  task automatic model(input bit dat, st, input logic [31:0] a, rl, input int ack_at);
    bit mis, ok;
    logic [31:0] v;
    mis    = (a[1:0] != 2'b00);
    ok     = !mis && ack_at >= 1 && ack_at <= T;
    e_strb = mis ? 0 : (ok ? ack_at : T);
    e_lat  = e_strb + 1;
    e_err  = !ok;
    e_ren  = !mis && !st;
    e_wen  = !mis && st;
    e_ir   = !dat;
    e_dr   = dat;
    e_addr = {a[31:2], 2'b00};
    if (!mis && !st) begin
      v = ok ? rl : 32'h0;
      if (dat) m_dmem = v; else m_imem = v;
    end
  endtask

  task automatic test_reset();
    rst = 1; tick(); tick();
    checks++;
    if ({ram_ren, ram_wen, i_ready, d_ready, err} !== 5'b0) begin
      errors++; $display("FAIL reset_ctl got %b exp 00000", {ram_ren, ram_wen, i_ready, d_ready, err});
    end
    checks++;
    if ({ramaddr, ramstore, imemload, dmemload} !== 128'h0) begin
      errors++; $display("FAIL reset_data got %h %h %h %h exp all 0", ramaddr, ramstore, imemload, dmemload);
    end
    rst = 0; m_imem = 0; m_dmem = 0;
    tick();
    ram_ack = 1; tick(); ram_ack = 0; tick();
    checks++;
    if ({ram_ren, ram_wen, i_ready, d_ready, err} !== 5'b0) begin
      errors++; $display("FAIL idle_ack got %b exp 00000", {ram_ren, ram_wen, i_ready, d_ready, err});
    end
  endtask

  task automatic test_fetch();
    do_access(1, 0, 0, 32'h10, 0, 0, 32'h0020_8093, 3);
    model(0, 0, 32'h10, 32'h0020_8093, 3);
    checks++;
    if (o_strb != 3 || {o_ren, o_wen, o_both, o_stable} !== 4'b1001 || o_addr !== 32'h10) begin
      errors++; $display("FAIL fetch_strobe got n=%0d rwbs=%b addr=%h exp n=3 rwbs=1001 addr=10",
                         o_strb, {o_ren, o_wen, o_both, o_stable}, o_addr);
    end
    checks++;
    if (o_lat != 4 || o_width != 1 || {o_ir, o_dr, o_err} !== 3'b100) begin
      errors++; $display("FAIL fetch_ready got lat=%0d w=%0d ide=%b exp lat=4 w=1 ide=100",
                         o_lat, o_width, {o_ir, o_dr, o_err});
    end
    checks++;
    if (o_iload !== 32'h0020_8093) begin
      errors++; $display("FAIL fetch_data got %h exp 00208093", o_iload);
    end
  endtask

  task automatic test_load_store();
    logic [31:0] rl;
    rl = $urandom;
    do_access(0, 1, 0, 0, 32'h200, 0, rl, 1);
    model(1, 0, 32'h200, rl, 1);
    checks++;
    if (o_strb != 1 || o_ren !== 1 || o_lat != 2 || {o_dr, o_err} !== 2'b10 || o_dload !== rl) begin
      errors++; $display("FAIL load_fast got n=%0d ren=%b lat=%0d de=%b d=%h exp n=1 ren=1 lat=2 de=10 d=%h",
                         o_strb, o_ren, o_lat, {o_dr, o_err}, o_dload, rl);
    end
    do_access(0, 1, 1, 0, 32'h204, 32'h1234_5678, $urandom, 1);
    model(1, 1, 32'h204, 0, 1);
    checks++;
    if ({o_ren, o_wen} !== 2'b01 || o_addr !== 32'h204 || o_store !== 32'h1234_5678) begin
      errors++; $display("FAIL store_prio got rw=%b addr=%h st=%h exp rw=01 addr=204 st=12345678",
                         {o_ren, o_wen}, o_addr, o_store);
    end
    checks++;
    if (o_lat != 2 || {o_dr, o_err} !== 2'b10 || o_dload !== rl) begin
      errors++; $display("FAIL store_done got lat=%0d de=%b d=%h exp lat=2 de=10 d=%h",
                         o_lat, {o_dr, o_err}, o_dload, rl);
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] prev;
    prev = m_dmem;
    do_access(0, 1, 0, 0, 32'h102, 0, $urandom, 0);
    model(1, 0, 32'h102, 0, 0);
    checks++;
    if (o_strb != 0 || o_lat != 1 || o_width != 1 || {o_ir, o_dr, o_err} !== 3'b011 || o_dload !== prev) begin
      errors++; $display("FAIL misaligned got n=%0d lat=%0d w=%0d ide=%b d=%h exp n=0 lat=1 w=1 ide=011 d=%h",
                         o_strb, o_lat, o_width, {o_ir, o_dr, o_err}, o_dload, prev);
    end
  endtask

  task automatic test_timeout();
    do_access(1, 0, 0, 32'h80, 0, 0, $urandom, 0);
    model(0, 0, 32'h80, 0, 0);
    checks++;
    if (o_strb != T || o_lat != T + 1 || {o_ir, o_err} !== 2'b11 || o_iload !== 32'h0) begin
      errors++; $display("FAIL timeout got n=%0d lat=%0d ie=%b i=%h exp n=%0d lat=%0d ie=11 i=0",
                         o_strb, o_lat, {o_ir, o_err}, o_iload, T, T + 1);
    end
    do_access(1, 0, 0, 32'h84, 0, 0, 32'hA5A5_0001, T);
    model(0, 0, 32'h84, 32'hA5A5_0001, T);
    checks++;
    if (o_strb != T || o_lat != T + 1 || {o_ir, o_err} !== 2'b10 || o_iload !== 32'hA5A5_0001) begin
      errors++; $display("FAIL ack_at_limit got n=%0d lat=%0d ie=%b i=%h exp n=%0d lat=%0d ie=10 i=a5a50001",
                         o_strb, o_lat, {o_ir, o_err}, o_iload, T, T + 1);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_v [1:6];
    exp_v[1] = 4'b1000; exp_v[2] = 4'b0010; exp_v[3] = 4'b0000;
    exp_v[4] = 4'b0100; exp_v[5] = 4'b0001; exp_v[6] = 4'b0000;
    i_req = 1; d_wen = 1; dmemaddr = 32'h100; dmemstore = 32'hCAFE_F00D;
    imemaddr = 32'h40; ramload = 32'h13;
    for (int c = 1; c <= 6; c++) begin
      tick();
      checks++;
      if ({ram_wen, ram_ren, d_ready, i_ready} !== exp_v[c] || err !== 1'b0) begin
        errors++; $display("FAIL b2b_c%0d got wrdi=%b err=%b exp %b err=0",
                           c, {ram_wen, ram_ren, d_ready, i_ready}, err, exp_v[c]);
      end
      if (c == 1) begin
        checks++;
        if (ramaddr !== 32'h100 || ramstore !== 32'hCAFE_F00D) begin
          errors++; $display("FAIL b2b_store got a=%h s=%h exp a=100 s=cafef00d", ramaddr, ramstore);
        end
      end
      if (c == 4) begin
        checks++;
        if (ramaddr !== 32'h40) begin
          errors++; $display("FAIL b2b_fetch_addr got %h exp 40", ramaddr);
        end
      end
      if (c == 5) begin
        checks++;
        if (imemload !== 32'h13) begin
          errors++; $display("FAIL b2b_fetch_data got %h exp 13", imemload);
        end
      end
      ram_ack = (c == 1 || c == 4);
      if (c == 2) d_wen = 0;
      if (c == 5) i_req = 0;
    end
    ram_ack = 0;
    m_imem = 32'h13;
  endtask

  task automatic test_reset_mid();
    int rdy;
    rdy = 0;
    d_wen = 1; dmemaddr = 32'h300; dmemstore = $urandom;
    tick(); d_wen = 0;
    tick();
    checks++;
    if (ram_wen !== 1'b1) begin
      errors++; $display("FAIL rst_mid_pre got wen=%b exp 1", ram_wen);
    end
    #2 rst = 1; #1;
    checks++;
    if ({ram_wen, ram_ren, d_ready} !== 3'b000) begin
      errors++; $display("FAIL rst_mid_async got wrd=%b exp 000", {ram_wen, ram_ren, d_ready});
    end
    tick(); rst = 0; m_imem = 0; m_dmem = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (d_ready || i_ready || ram_wen || ram_ren) rdy++;
    end
    checks++;
    if (rdy != 0) begin
      errors++; $display("FAIL rst_mid_quiet got %0d active cycles exp 0", rdy);
    end
    do_access(1, 0, 0, 32'h20, 0, 0, 32'h7777_0000, 2);
    model(0, 0, 32'h20, 32'h7777_0000, 2);
    checks++;
    if (o_lat != 3 || {o_ir, o_err} !== 2'b10 || o_iload !== 32'h7777_0000) begin
      errors++; $display("FAIL rst_mid_after got lat=%0d ie=%b i=%h exp lat=3 ie=10 i=77770000",
                         o_lat, {o_ir, o_err}, o_iload);
    end
  endtask

  task automatic test_random();
    int          kind, ack_at;
    logic [31:0] a, ds, rl;
    bit          dat, st;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(3);
      dat  = (kind != 0);
      st   = (kind >= 2);
      a    = $urandom;
      if ($urandom_range(5) != 0) a[1:0] = 2'b00;
      ds   = $urandom;
      rl   = $urandom;
      ack_at = st ? $urandom_range(T, 1) : $urandom_range(T + 1);
      do_access(!dat || $urandom_range(1) == 1, dat && (kind != 2), st,
                dat ? $urandom : a, dat ? a : $urandom, ds, rl, ack_at);
      model(dat, st, a, rl, ack_at);
      checks++;
      if (o_strb != e_strb || o_lat != e_lat || o_width != 1) begin
        errors++; $display("FAIL rnd%0d_timing got n=%0d lat=%0d w=%0d exp n=%0d lat=%0d w=1",
                           n, o_strb, o_lat, o_width, e_strb, e_lat);
      end
      checks++;
      if ({o_ren, o_wen, o_both, o_stable, o_ir, o_dr, o_err} !== {e_ren, e_wen, 2'b01, e_ir, e_dr, e_err}) begin
        errors++; $display("FAIL rnd%0d_flags got %b exp %b", n,
                           {o_ren, o_wen, o_both, o_stable, o_ir, o_dr, o_err},
                           {e_ren, e_wen, 2'b01, e_ir, e_dr, e_err});
      end
      checks++;
      if (e_strb > 0 && (o_addr !== e_addr || (st && o_store !== ds))) begin
        errors++; $display("FAIL rnd%0d_ram got a=%h s=%h exp a=%h s=%h", n, o_addr, o_store, e_addr, ds);
      end
      checks++;
      if (o_iload !== m_imem || o_dload !== m_dmem) begin
        errors++; $display("FAIL rnd%0d_data got i=%h d=%h exp i=%h d=%h", n, o_iload, o_dload, m_imem, m_dmem);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fetch();
    test_load_store();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
